ins_fetch: RTL and testbench
============================

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter RESET_PC, default 12'h000: program counter value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles to wait for mem_ready before the fetch is aborted; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fetch_en  input  1  request to fetch the next instruction; sampled only in IDLE.
REQ-006 jump  input  1  load pc from jump_addr; sampled only in IDLE.
REQ-007 jump_addr  input  12  jump target.
REQ-008 mem_rd  output  1  instruction-memory read strobe.
REQ-009 mem_addr  output  12  instruction-memory address.
REQ-010 mem_rdata  input  16  instruction-memory read data; valid when mem_ready=1.
REQ-011 mem_ready  input  1  memory has data for the current read.
REQ-012 insout  output  16  fetched instruction; drives the instruction-register data input.
REQ-013 loadIR  output  1  one-cycle load strobe for the instruction register.
REQ-014 pc  output  12  current program counter.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 fetch_err  output  1  one-cycle pulse on a timeout abort.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, REQ, LOAD. All outputs SHALL be registered.
REQ-018 In IDLE with jump=1, the block SHALL set pc<=jump_addr; jump takes effect whatever the value of fetch_en.
REQ-019 In IDLE with fetch_en=1, the block SHALL go to REQ, assert mem_rd=1 and set mem_addr to the new pc, which is jump_addr when jump=1 in the same cycle and pc otherwise.
REQ-020 In REQ, mem_rd and mem_addr SHALL be held stable until mem_ready=1 is sampled.
REQ-021 When mem_ready=1 is sampled in REQ, the block SHALL:
- capture insout<=mem_rdata;
- set pc<=pc+1;
- deassert mem_rd;
- go to LOAD.
REQ-022 In LOAD, loadIR SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE and loadIR SHALL return to 0.
REQ-023 insout SHALL stay constant from the capture until the next successful capture.
REQ-024 Latency: with mem_ready=1 on the first REQ cycle, loadIR SHALL be high in the 3rd cycle after the fetch_en sample edge. Back-to-back fetches SHALL issue one instruction every 3 cycles.
REQ-025 pc increment SHALL wrap modulo 2^12: 12'hFFF+1 = 12'h000, with no flag raised.
REQ-026 In REQ and LOAD, fetch_en and jump SHALL be ignored; the controller is responsible for using busy.
REQ-027 A wait counter SHALL clear on entry to REQ and increment on each REQ cycle with mem_ready=0.
REQ-028 If the wait counter reaches TIMEOUT with mem_ready still 0, the block SHALL:
- deassert mem_rd;
- pulse fetch_err for one cycle;
- return to IDLE with pc and insout unchanged and no loadIR pulse.
REQ-029 If mem_ready=1 arrives in the same cycle the count reaches TIMEOUT, the fetch SHALL succeed and no error is raised.
REQ-030 mem_ready in IDLE or LOAD SHALL be ignored.

Reset
REQ-031 While rst_n=0, the block SHALL immediately and asynchronously force:
- state=IDLE, pc=RESET_PC, mem_addr=RESET_PC;
- mem_rd=0, loadIR=0, fetch_err=0, busy=0;
- insout=16'h0000, wait counter=0.
REQ-032 Reset asserted mid-fetch (REQ or LOAD) SHALL abort the fetch with no loadIR pulse; the first fetch after reset SHALL read from RESET_PC.
REQ-033 The block SHALL leave reset on the first posedge clk with rst_n=1 and SHALL sample fetch_en from that edge.

Verification
REQ-034 Reset, then fetch_en=1 for one cycle, mem_ready=1 immediately with mem_rdata=16'h3ABC -> mem_rd=1 with mem_addr=12'h000; insout=16'h3ABC; loadIR high for one cycle on cycle 3; pc=12'h001.
REQ-035 jump=1 with jump_addr=12'h7F0 and fetch_en=1 in the same cycle, mem_rdata=16'h1234 -> mem_addr=12'h7F0; pc=12'h7F1 after the fetch; insout=16'h1234.
REQ-036 jump to 12'hFFF, fetch with mem_rdata=16'hF00D -> pc=12'h000 after the fetch; next fetch reads mem_addr=12'h000.
REQ-037 TIMEOUT=15, mem_ready held 0 -> fetch_err pulses once; no loadIR; pc unchanged; busy=0 afterwards. Repeat with mem_ready=1 on the 15th wait cycle -> fetch succeeds and fetch_err stays 0.
REQ-038 rst_n pulsed low in REQ after 3 wait cycles -> mem_rd=0 and busy=0 immediately; no loadIR pulse; a later fetch reads from RESET_PC.
REQ-039 fetch_en held high for 4 fetches with mem_ready=1, then a jump pulse during LOAD -> 4 loadIR pulses spaced 3 cycles apart; pc advances by 4; the jump is ignored.

Source files
------------

// File: rtl/ins_fetch.sv
// Instruction fetch controller: IDLE -> REQ -> LOAD handshake with instruction memory,
// program counter tracking, jump handling and a bounded wait for mem_ready.
module ins_fetch #(
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        jump,
  input  logic [11:0] jump_addr,
  output logic        mem_rd,
  output logic [11:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] insout,
  output logic        loadIR,
  output logic [11:0] pc,
  output logic        busy,
  output logic        fetch_err
);

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  // Last wait count that still fits inside the TIMEOUT window.
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [AW-1:0]   pc_q,        pc_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic            mem_rd_q,    mem_rd_d;
  logic [DW-1:0]   insout_q,    insout_d;
  logic            loadir_q,    loadir_d;
  logic            busy_q,      busy_d;
  logic            fetch_err_q, fetch_err_d;
  logic [CW-1:0]   wait_cnt_q,  wait_cnt_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    insout_d    = insout_q;
    loadir_d    = 1'b0;
    fetch_err_d = 1'b0;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (jump) begin
          pc_d = jump_addr;
        end
        if (fetch_en) begin
          state_d    = REQ;
          mem_rd_d   = 1'b1;
          mem_addr_d = jump ? jump_addr : pc_q;
          wait_cnt_d = '0;
        end
      end
      REQ: begin
        // A ready on the final allowed wait cycle still wins over the timeout.
        if (mem_ready) begin
          insout_d = mem_rdata;
          pc_d     = pc_q + AW'(1);
          mem_rd_d = 1'b0;
          state_d  = LOAD;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          mem_rd_d    = 1'b0;
          fetch_err_d = 1'b1;
          wait_cnt_d  = wait_cnt_q + CW'(1);
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      LOAD: begin
        loadir_d = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      mem_addr_q  <= RESET_PC;
      mem_rd_q    <= 1'b0;
      insout_q    <= '0;
      loadir_q    <= 1'b0;
      busy_q      <= 1'b0;
      fetch_err_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      insout_q    <= insout_d;
      loadir_q    <= loadir_d;
      busy_q      <= busy_d;
      fetch_err_q <= fetch_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign insout    = insout_q;
  assign loadIR    = loadir_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed vector table, reset corner cases,
// randomized fetches against a transaction-level pc/insout model, back-to-back streaming.
module tb_ins_fetch;

  localparam int unsigned TMO = 15;
  localparam logic [11:0] RST_PC = 12'h000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        jump;
  logic [11:0] jump_addr;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] insout;
  logic        loadIR;
  logic [11:0] pc;
  logic        busy;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  ins_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .jump      (jump),
    .jump_addr (jump_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .insout    (insout),
    .loadIR    (loadIR),
    .pc        (pc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jmp;
    logic [11:0] jaddr;
    int          delay;     // REQ cycle index (0-based) on which mem_ready rises
    logic [15:0] data;
    logic [11:0] exp_addr;
    logic        exp_ok;
    logic [11:0] exp_pc;
    logic [15:0] exp_ins;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One complete fetch transaction; memory answers on REQ cycle 'delay'.
  task automatic do_fetch(input logic jmp, input logic [11:0] jaddr, input int delay,
                          input logic [15:0] data, input logic [11:0] exp_addr,
                          input logic exp_ok, input logic [11:0] exp_pc,
                          input logic [15:0] exp_ins);
    bit done = 0;
    @(negedge clk);
    fetch_en  = 1'b1;
    jump      = jmp;
    jump_addr = jaddr;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    fetch_en = 1'b0;
    jump     = 1'b0;
    chk("req_mem_rd", mem_rd, 1'b1);
    chk("req_mem_addr", mem_addr, exp_addr);
    chk("req_busy", busy, 1'b1);
    chk("req_loadIR", loadIR, 1'b0);
    for (int k = 0; k < int'(TMO); k++) begin
      if (!done) begin
        @(negedge clk);
        mem_ready = (k == delay);
        mem_rdata = (k == delay) ? data : 16'($urandom);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        if (exp_ok && k == delay) begin
          done = 1;
          chk("ok_mem_rd", mem_rd, 1'b0);
          chk("ok_busy", busy, 1'b1);
          chk("ok_fetch_err", fetch_err, 1'b0);
          chk("ok_insout", insout, exp_ins);
          chk("ok_pc", pc, exp_pc);
          @(posedge clk);
          #1;
          chk("load_loadIR", loadIR, 1'b1);
          chk("load_busy", busy, 1'b0);
          chk("load_fetch_err", fetch_err, 1'b0);
        end else if (!exp_ok && k == int'(TMO) - 1) begin
          done = 1;
          chk("tmo_fetch_err", fetch_err, 1'b1);
          chk("tmo_mem_rd", mem_rd, 1'b0);
          chk("tmo_busy", busy, 1'b0);
          chk("tmo_loadIR", loadIR, 1'b0);
          chk("tmo_pc", pc, exp_pc);
          chk("tmo_insout", insout, exp_ins);
          @(posedge clk);
          #1;
          chk("tmo_err_pulse", fetch_err, 1'b0);
          chk("tmo_no_load", loadIR, 1'b0);
        end else begin
          chk("wait_mem_rd", mem_rd, 1'b1);
          chk("wait_mem_addr", mem_addr, exp_addr);
          chk("wait_busy", busy, 1'b1);
          chk("wait_fetch_err", fetch_err, 1'b0);
        end
      end
    end
    if (!done) chk("fetch_completed", 32'd0, 32'd1);
  endtask

  logic [11:0] m_pc;
  logic [15:0] m_ins;

  initial begin
    logic [11:0] a;
    logic [15:0] d;
    logic [15:0] last_d;
    logic [11:0] start_pc;
    logic        j;
    int          dl;
    bit          ok;
    bit          in_load;

    rst_n = 1'b0; fetch_en = 1'b0; jump = 1'b0; jump_addr = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    vecs[0] = '{1'b0, 12'h000, 0,       16'h3ABC, 12'h000, 1'b1, 12'h001, 16'h3ABC};
    vecs[1] = '{1'b1, 12'h7F0, 0,       16'h1234, 12'h7F0, 1'b1, 12'h7F1, 16'h1234};
    vecs[2] = '{1'b1, 12'hFFF, 1,       16'hF00D, 12'hFFF, 1'b1, 12'h000, 16'hF00D};
    vecs[3] = '{1'b0, 12'h555, 2,       16'h0BAD, 12'h000, 1'b1, 12'h001, 16'h0BAD};
    vecs[4] = '{1'b0, 12'h000, 99,      16'hDEAD, 12'h001, 1'b0, 12'h001, 16'h0BAD};
    vecs[5] = '{1'b0, 12'h000, TMO - 1, 16'h5A5A, 12'h001, 1'b1, 12'h002, 16'h5A5A};
    vecs[6] = '{1'b1, 12'h123, TMO + 3, 16'hBEEF, 12'h123, 1'b0, 12'h123, 16'h5A5A};

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_mem_addr", mem_addr, RST_PC);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_loadIR", loadIR, 1'b0);
    chk("rst_fetch_err", fetch_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_insout", insout, 16'h0000);
    #1 rst_n = 1'b1;

    // First edge out of reset samples fetch_en.
    foreach (vecs[i])
      do_fetch(vecs[i].jmp, vecs[i].jaddr, vecs[i].delay, vecs[i].data,
               vecs[i].exp_addr, vecs[i].exp_ok, vecs[i].exp_pc, vecs[i].exp_ins);

    // Reset asserted in REQ after 3 wait cycles.
    @(negedge clk);
    fetch_en = 1'b1;
    @(posedge clk);
    #1 fetch_en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_rd", mem_rd, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_mem_addr", mem_addr, RST_PC);
    chk("midrst_insout", insout, 16'h0000);
    @(posedge clk);
    #1 chk("midrst_loadIR", loadIR, 1'b0);
    #1 rst_n = 1'b1;
    do_fetch(1'b0, 12'h0, 0, 16'hC0DE, RST_PC, 1'b1, RST_PC + 12'd1, 16'hC0DE);
    m_pc  = RST_PC + 12'd1;
    m_ins = 16'hC0DE;

    // Randomized fetches with idle gaps; model tracks pc and insout by spec rules.
    for (int t = 0; t < 40; t++) begin
      int gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        j         = ($urandom_range(0, 3) == 0);
        jump      = j;
        jump_addr = 12'($urandom);
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        if (j) m_pc = jump_addr;
        @(posedge clk);
        #1;
        jump = 1'b0; mem_ready = 1'b0;
        chk("idle_pc", pc, m_pc);
        chk("idle_busy", busy, 1'b0);
        chk("idle_insout", insout, m_ins);
      end
      j  = ($urandom_range(0, 3) == 0);
      a  = 12'($urandom);
      d  = 16'($urandom);
      dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 2)) : int'($urandom_range(0, 3));
      ok = (dl < int'(TMO));
      if (j) m_pc = a;
      if (ok) begin
        do_fetch(j, a, dl, d, m_pc, 1'b1, m_pc + 12'd1, d);
        m_pc  = m_pc + 12'd1;
        m_ins = d;
      end else begin
        do_fetch(j, a, dl, d, m_pc, 1'b0, m_pc, m_ins);
      end
    end

    // fetch_en held high for four fetches, jump pulses in LOAD must be ignored.
    start_pc = m_pc;
    last_d   = m_ins;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      in_load   = (c % 3 == 2) && (c <= 11);
      fetch_en  = (c <= 11);
      jump      = in_load;
      jump_addr = 12'($urandom);
      mem_ready = 1'b1;
      d         = 16'($urandom);
      mem_rdata = d;
      if (c % 3 == 1 && c <= 11) last_d = d;
      @(posedge clk);
      #1;
      chk("b2b_loadIR", loadIR, in_load);
      if (c % 3 == 0 && c <= 11)
        chk("b2b_mem_addr", mem_addr, start_pc + 12'(c / 3));
    end
    fetch_en = 1'b0; jump = 1'b0; mem_ready = 1'b0;
    chk("b2b_pc", pc, start_pc + 12'd4);
    chk("b2b_insout", insout, last_d);
    chk("b2b_busy", busy, 1'b0);
    chk("b2b_mem_rd", mem_rd, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
